// File: rtl/nn_batch_sequencer.sv
// Batch sequencer for one neural_network instance: per sample it fills the network,
// runs inference, then copies the network output RAM into the batch result buffer.
module nn_batch_sequencer #(
  parameter int DATA_W    = 8,
  parameter int N_IN      = 2,
  parameter int N_OUT     = 1,
  parameter int N_SAMPLES = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic error,
  output logic [((N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1)-1:0] sample_idx,
  output logic [((N_SAMPLES*N_IN > 1) ? $clog2(N_SAMPLES*N_IN) : 1)-1:0] in_base,
  output logic nn_fill,
  input  logic nn_ack_fill,
  output logic nn_req,
  input  logic nn_ack_network,
  output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] res_rd_addr,
  input  logic signed [DATA_W-1:0] res_rd_data,
  output logic res_wr_en,
  output logic [((N_SAMPLES*N_OUT > 1) ? $clog2(N_SAMPLES*N_OUT) : 1)-1:0] res_wr_addr,
  output logic signed [DATA_W-1:0] res_wr_data
);

  localparam int SW  = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int IW  = (N_SAMPLES*N_IN > 1) ? $clog2(N_SAMPLES*N_IN) : 1;
  localparam int RAW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int OW  = (N_SAMPLES*N_OUT > 1) ? $clog2(N_SAMPLES*N_OUT) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int CW  = $clog2(N_OUT + 1);

  typedef enum logic [2:0] {IDLE, FILL, RUN, COPY, NEXT, DONE} state_t;

  state_t          state, state_next;
  logic [TW-1:0]   wait_cnt, wait_cnt_next, wait_inc;
  logic [CW-1:0]   copy_cnt, copy_cnt_next;
  logic [OW-1:0]   out_base, out_base_next;
  logic            busy_next, done_next, error_next, fill_next, req_next;
  logic [SW-1:0]   sample_next;
  logic [IW-1:0]   in_base_next;
  logic [RAW-1:0]  rd_addr_next;
  logic            wr_en_next;
  logic [OW-1:0]   wr_addr_next;
  logic            timed_out;

  assign wait_inc  = wait_cnt + 1'b1;
  assign timed_out = (wait_inc == TW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      sample_idx  <= '0;
      in_base     <= '0;
      out_base    <= '0;
      nn_fill     <= 1'b0;
      nn_req      <= 1'b0;
      wait_cnt    <= '0;
      copy_cnt    <= '0;
      res_rd_addr <= '0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
    end else begin
      state       <= state_next;
      busy        <= busy_next;
      done        <= done_next;
      error       <= error_next;
      sample_idx  <= sample_next;
      in_base     <= in_base_next;
      out_base    <= out_base_next;
      nn_fill     <= fill_next;
      nn_req      <= req_next;
      wait_cnt    <= wait_cnt_next;
      copy_cnt    <= copy_cnt_next;
      res_rd_addr <= rd_addr_next;
      res_wr_en   <= wr_en_next;
      res_wr_addr <= wr_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    busy_next     = busy;
    done_next     = 1'b0;
    error_next    = error;
    sample_next   = sample_idx;
    in_base_next  = in_base;
    out_base_next = out_base;
    fill_next     = nn_fill;
    req_next      = nn_req;
    wait_cnt_next = wait_cnt;
    copy_cnt_next = copy_cnt;
    rd_addr_next  = res_rd_addr;
    wr_en_next    = 1'b0;
    wr_addr_next  = res_wr_addr;
    case (state)
      IDLE: begin
        if (start) begin
          state_next    = FILL;
          busy_next     = 1'b1;
          error_next    = 1'b0;
          sample_next   = '0;
          in_base_next  = '0;
          out_base_next = '0;
          fill_next     = 1'b1;
          wait_cnt_next = '0;
        end
      end
      FILL: begin
        // An ack landing on the timeout cycle still counts as success.
        if (nn_ack_fill) begin
          state_next    = RUN;
          fill_next     = 1'b0;
          wait_cnt_next = '0;
        end else if (timed_out) begin
          state_next = IDLE;
          fill_next  = 1'b0;
          busy_next  = 1'b0;
          error_next = 1'b1;
        end else begin
          wait_cnt_next = wait_inc;
        end
      end
      RUN: begin
        // req is only raised once the fill ack has been withdrawn.
        if (nn_req && nn_ack_network) begin
          state_next    = COPY;
          req_next      = 1'b0;
          copy_cnt_next = '0;
          rd_addr_next  = '0;
        end else if (timed_out) begin
          state_next = IDLE;
          req_next   = 1'b0;
          busy_next  = 1'b0;
          error_next = 1'b1;
        end else begin
          wait_cnt_next = wait_inc;
          if (!nn_ack_fill) req_next = 1'b1;
        end
      end
      COPY: begin
        // p0: read address j; p1: write of word j one cycle later
        if (copy_cnt == CW'(N_OUT)) begin
          state_next   = NEXT;
          rd_addr_next = '0;
        end else begin
          copy_cnt_next = copy_cnt + 1'b1;
          wr_en_next    = 1'b1;
          wr_addr_next  = out_base + OW'(copy_cnt);
          if (int'(copy_cnt) + 1 < N_OUT) rd_addr_next = RAW'(copy_cnt + 1'b1);
        end
      end
      NEXT: begin
        if (sample_idx == SW'(N_SAMPLES - 1)) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          state_next    = FILL;
          sample_next   = sample_idx + 1'b1;
          in_base_next  = in_base + IW'(N_IN);
          out_base_next = out_base + OW'(N_OUT);
          fill_next     = 1'b1;
          wait_cnt_next = '0;
        end
      end
      DONE: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  assign res_wr_data = res_wr_en ? res_rd_data : '0;

endmodule

// File: tb/tb_nn_batch_sequencer.sv
// Directed bench for nn_batch_sequencer: instance a (N_OUT=1, TIMEOUT=20) and
// instance b (N_OUT=3) each driven by a small neural_network handshake model.
module tb_nn_batch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // instance a
  logic start_a = 1'b0, busy_a, done_a, error_a;
  logic [1:0] sidx_a;
  logic [2:0] in_base_a;
  logic fill_a, ack_fill_a = 1'b0, req_a, ack_net_a = 1'b0;
  logic [0:0] rd_addr_a;
  logic signed [7:0] rd_data_a = '0;
  logic wr_en_a;
  logic [1:0] wr_addr_a;
  logic signed [7:0] wr_data_a;
  logic hold_fill_a = 1'b0;

  nn_batch_sequencer #(.DATA_W(8), .N_IN(2), .N_OUT(1), .N_SAMPLES(4), .TIMEOUT(20)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .error(error_a),
    .sample_idx(sidx_a), .in_base(in_base_a), .nn_fill(fill_a), .nn_ack_fill(ack_fill_a),
    .nn_req(req_a), .nn_ack_network(ack_net_a), .res_rd_addr(rd_addr_a),
    .res_rd_data(rd_data_a), .res_wr_en(wr_en_a), .res_wr_addr(wr_addr_a),
    .res_wr_data(wr_data_a));

  // instance b
  logic start_b = 1'b0, busy_b, done_b, error_b;
  logic [1:0] sidx_b;
  logic [2:0] in_base_b;
  logic fill_b, ack_fill_b = 1'b0, req_b, ack_net_b = 1'b0;
  logic [1:0] rd_addr_b;
  logic signed [7:0] rd_data_b = '0;
  logic wr_en_b;
  logic [3:0] wr_addr_b;
  logic signed [7:0] wr_data_b;

  nn_batch_sequencer #(.DATA_W(8), .N_IN(2), .N_OUT(3), .N_SAMPLES(4), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .error(error_b),
    .sample_idx(sidx_b), .in_base(in_base_b), .nn_fill(fill_b), .nn_ack_fill(ack_fill_b),
    .nn_req(req_b), .nn_ack_network(ack_net_b), .res_rd_addr(rd_addr_b),
    .res_rd_data(rd_data_b), .res_wr_en(wr_en_b), .res_wr_addr(wr_addr_b),
    .res_wr_data(wr_data_b));

  // network models: ack_fill after 3 cycles of fill, ack_network ~10 cycles after req
  int fcnt_a = 0, ncnt_a = 0, fcnt_b = 0, ncnt_b = 0;
  logic signed [7:0] word_a = '0;

  always @(posedge clk) begin
    fcnt_a     <= (fill_a && !hold_fill_a) ? fcnt_a + 1 : 0;
    ack_fill_a <= fill_a && !hold_fill_a && (fcnt_a >= 3);
    ncnt_a     <= req_a ? ncnt_a + 1 : 0;
    ack_net_a  <= req_a && (ncnt_a >= 9);
    if (req_a && ncnt_a == 9) word_a <= 8'(8 * (int'(in_base_a) + 2));
    rd_data_a  <= (rd_addr_a == 1'b0) ? word_a : 8'sd0;

    fcnt_b     <= fill_b ? fcnt_b + 1 : 0;
    ack_fill_b <= fill_b && (fcnt_b >= 3);
    ncnt_b     <= req_b ? ncnt_b + 1 : 0;
    ack_net_b  <= req_b && (ncnt_b >= 9);
    case (rd_addr_b)
      2'd0:    rd_data_b <= -8'sd5;
      2'd1:    rd_data_b <= 8'sd0;
      2'd2:    rd_data_b <= 8'sd127;
      default: rd_data_b <= 8'sd0;
    endcase
  end

  // monitors
  logic [7:0] res_a [4];
  logic [7:0] res_b [12];
  logic [2:0] ib_log [64];
  int ib_n = 0, done_cnt_a = 0, done_cnt_b = 0, hs_viol = 0, dbl_done = 0;
  int run_b = 0, gap_viol = 0, wr_cnt_b = 0;
  logic fill_a_q = 1'b0, done_a_q = 1'b0;

  always @(negedge clk) begin
    if ((fill_a && req_a) || (fill_b && req_b) || (req_a && ack_fill_a) || (req_b && ack_fill_b))
      hs_viol <= hs_viol + 1;
    if (fill_a && !fill_a_q && ib_n < 64) begin
      ib_log[ib_n] <= in_base_a;
      ib_n <= ib_n + 1;
    end
    fill_a_q <= fill_a;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_a && done_a_q) dbl_done <= dbl_done + 1;
    done_a_q <= done_a;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (wr_en_a) res_a[wr_addr_a] <= wr_data_a;
    if (wr_en_b) begin
      if (wr_addr_b < 4'd12) res_b[wr_addr_b] <= wr_data_b;
      wr_cnt_b <= wr_cnt_b + 1;
      run_b <= run_b + 1;
    end else begin
      if (run_b != 0 && run_b != 3) gap_viol <= gap_viol + 1;
      run_b <= 0;
    end
  end

  task automatic pulse_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (!done_a && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done_a}, 32'd1);
  endtask

  int base_ib, base_done, n;
  logic [7:0] exp_a [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
  logic [7:0] exp_b [3] = '{8'hFB, 8'h00, 8'h7F};

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy_a}, 0);
    check("rst_done", {31'd0, done_a}, 0);
    check("rst_error", {31'd0, error_a}, 0);
    check("rst_sidx", {30'd0, sidx_a}, 0);
    check("rst_in_base", {29'd0, in_base_a}, 0);
    check("rst_fill", {31'd0, fill_a}, 0);
    check("rst_req", {31'd0, req_a}, 0);
    check("rst_wr_en", {31'd0, wr_en_a}, 0);
    check("rst_wr_data", {24'd0, $unsigned(wr_data_a)}, 0);
    rst = 1'b0;
    @(negedge clk);

    // nominal batch
    base_ib = ib_n;
    base_done = done_cnt_a;
    pulse_a();
    check("nom_busy_after_start", {31'd0, busy_a}, 1);
    wait_done_a("nom");
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("nom_res%0d", i), {24'd0, res_a[i]}, {24'd0, exp_a[i]});
    check("nom_fill_count", ib_n - base_ib, 4);
    for (int i = 0; i < 4; i++) check($sformatf("nom_in_base%0d", i), {29'd0, ib_log[base_ib + i]}, 2 * i);
    check("nom_done_count", done_cnt_a - base_done, 1);
    check("nom_busy_idle", {31'd0, busy_a}, 0);
    check("nom_sidx_hold", {30'd0, sidx_a}, 3);
    check("nom_in_base_hold", {29'd0, in_base_a}, 6);

    // timeout on fill
    hold_fill_a = 1'b1;
    base_done = done_cnt_a;
    pulse_a();
    check("to_fill_up", {31'd0, fill_a}, 1);
    n = 0;
    while (!error_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, 20);
    check("to_fill_low", {31'd0, fill_a}, 0);
    check("to_busy_low", {31'd0, busy_a}, 0);
    repeat (2) @(negedge clk);
    check("to_no_done", done_cnt_a - base_done, 0);
    check("to_error_sticky", {31'd0, error_a}, 1);

    // next start clears error and completes
    hold_fill_a = 1'b0;
    base_done = done_cnt_a;
    pulse_a();
    check("clr_error", {31'd0, error_a}, 0);
    wait_done_a("clr");
    repeat (2) @(negedge clk);
    check("clr_done_count", done_cnt_a - base_done, 1);
    check("clr_error_final", {31'd0, error_a}, 0);

    // start held through whole batch and DONE cycle
    start_a = 1'b1;
    wait_done_a("held");
    @(negedge clk);
    check("held_idle_busy", {31'd0, busy_a}, 0);
    check("held_idle_done", {31'd0, done_a}, 0);
    @(negedge clk);
    check("held_restart_busy", {31'd0, busy_a}, 1);
    check("held_restart_sidx", {30'd0, sidx_a}, 0);
    start_a = 1'b0;
    @(negedge clk);
    wait_done_a("held2");
    @(negedge clk);

    // multi-word copy on instance b
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("b_done_seen", {31'd0, done_b}, 1);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 3; k++)
        check($sformatf("b_res%0d", s * 3 + k), {24'd0, res_b[s * 3 + k]}, {24'd0, exp_b[k]});
    check("b_write_count", wr_cnt_b, 12);
    check("b_gap_runs", gap_viol, 0);
    check("b_done_count", done_cnt_b, 1);
    check("b_sidx_hold", {30'd0, sidx_b}, 3);
    check("b_in_base_hold", {29'd0, in_base_b}, 6);
    check("b_error", {31'd0, error_b}, 0);
    check("b_busy", {31'd0, busy_b}, 0);

    check("handshake_overlap", hs_viol, 0);
    check("done_single_cycle", dbl_done, 0);

    // asynchronous reset mid-RUN
    pulse_a();
    n = 0;
    while (!(sidx_a == 2'd2 && req_a) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ar_reached_run", {31'd0, req_a}, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_req", {31'd0, req_a}, 0);
    check("ar_busy", {31'd0, busy_a}, 0);
    check("ar_sidx", {30'd0, sidx_a}, 0);
    check("ar_in_base", {29'd0, in_base_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
